// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined 8-op logic unit with tag, valid/ready, flush
// Optional LU_FLAGS_EN adds pipelined out_zero/out_neg result flags.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_x1,
  input  logic [WIDTH-1:0] in_x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_y,
`ifdef LU_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
`endif
  output logic             busy
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  w_res;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] r_v;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [WIDTH-1:0]  r_y   [STAGES];
`ifdef LU_FLAGS_EN
  logic [STAGES-1:0] r_zero;
  logic [STAGES-1:0] r_neg;
`endif

  always_comb begin
    w_res = '0;
    case (in_opcode)
      3'd0: w_res = in_x1 & in_x2;
      3'd1: w_res = in_x1 ^ in_x2;
      3'd2: w_res = ~(in_x1 & in_x2);
      3'd3: w_res = in_x1 | in_x2;
      3'd4: w_res = ~in_x1;
      3'd5: w_res = ~(in_x1 | in_x2);
      3'd6: w_res = ~in_x1 + WIDTH'(1);
      3'd7: w_res = ~(in_x1 ^ in_x2);
      default: w_res = '0;
    endcase
  end

  // A stage may load when empty or when its occupant moves on; this
  // ripples back from the CDB grant so bubbles fill under backpressure.
  always_comb begin : load_chain
    logic w_next;
    w_load = '0;
    w_next = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      w_next    = !r_v[i] || w_next;
      w_load[i] = w_next;
    end
  end

  assign in_ready  = w_load[0];
  assign busy      = |r_v;
  assign out_valid = r_v[LAST];
  assign out_tag   = r_tag[LAST];
  assign out_y     = r_y[LAST];
`ifdef LU_FLAGS_EN
  assign out_zero  = r_zero[LAST];
  assign out_neg   = r_neg[LAST];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_tag[i] <= '0;
        r_y[i]   <= '0;
      end
`ifdef LU_FLAGS_EN
      r_zero <= '0;
      r_neg  <= '0;
`endif
    end else begin
      if (w_load[0]) begin
        r_v[0]   <= in_valid;
        r_tag[0] <= in_tag;
        r_y[0]   <= w_res;
`ifdef LU_FLAGS_EN
        r_zero[0] <= (w_res == '0);
        r_neg[0]  <= w_res[WIDTH-1];
`endif
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_v[i]   <= r_v[i-1];
          r_tag[i] <= r_tag[i-1];
          r_y[i]   <= r_y[i-1];
`ifdef LU_FLAGS_EN
          r_zero[i] <= r_zero[i-1];
          r_neg[i]  <= r_neg[i-1];
`endif
        end
      end
      // Data may still shift on a flush; only the valid bits matter.
      if (flush) r_v <= '0;
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-op logic unit; serves as the logic functional unit behind a reservation station in the Tomasulo core.
- Accepts one tagged operation per cycle over a valid/ready handshake.
- Computes the same 8 logical ops at configurable width, carries the tag through STAGES registered stages, and presents tag and result to the CDB arbiter via valid/ready with full backpressure and flush.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- TAG_W, 4, reservation-station tag width.
- STAGES, 2, pipeline depth in registered stages; legal range 1..4.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  squash all in-flight ops (mispredict/exception)
- in_valid  input  1  issue request
- in_ready  output  1  unit can accept this cycle
- in_tag  input  TAG_W  destination tag
- in_opcode  input  3  operation select
- in_x1  input  WIDTH  operand 1
- in_x2  input  WIDTH  operand 2
- out_valid  output  1  result available for CDB
- out_ready  input  1  CDB grant
- out_tag  output  TAG_W  tag of presented result
- out_y  output  WIDTH  result
- busy  output  1  any stage holds a valid op

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Opcodes:
  - 0 AND; 1 XOR; 2 NAND; 3 OR; 4 NOT x1; 5 NOR; 6 NEG x1 (~x1+1, modulo 2^WIDTH); 7 XNOR.
  - Ops 4 and 6 ignore x2.
- Compute point: result is evaluated combinationally from the in_* signals and captured into stage 1 on accept. Stages 2..STAGES carry {tag, result} only. The last stage drives out_*.
- Accept: a transfer occurs when in_valid && in_ready.
- Per-stage valid bit v[i]; advance[i] is true when v[i] && (i==last ? out_ready : (!v[i+1] || advance[i+1])).
  - Stage i loads from i-1 (or from input for i=1) when !v[i] || advance[i].
  - in_ready = !v[1] || advance[1]. in_ready is combinational from out_ready and state, never from in_valid.
- Latency: with no backpressure, an op accepted in cycle N shows out_valid=1 in cycle N+STAGES. Throughput is 1 op/cycle sustained while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, out_tag/out_y hold stable.
  - Upstream stages fill their bubbles; in_ready drops only when all STAGES are full.
  - Full occupancy is exactly STAGES ops; no op is dropped or duplicated.
- Output: out_valid = v[last]; out_tag/out_y = last-stage registers.
- busy: OR of all v[i].
- Flush:
  - On a cycle with flush=1, all v[i] clear at the next edge.
  - An accept in the same cycle is discarded, although in_ready may read 1.
  - A CDB handshake in the flush cycle still counts as delivered (the consumer sampled it).
  - Data registers need not clear.
- Reset:
  - All v[i]=0 and all data/tag registers = 0, so out_valid=0, out_tag=0, out_y=0, busy=0, in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight ops, with no output handshake.
  - rst has priority over flush.
- Unknown/X opcode: not possible (3-bit full decode).

Optional Feature:
- Macro: LU_FLAGS_EN.
- When defined:
  - Adds outputs out_zero (1) and out_neg (1).
  - out_zero = (result == 0); out_neg = result[WIDTH-1].
  - Both are computed at stage 1 and pipelined alongside the result; reset value 0; held stable under backpressure like out_y.
- When undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> out_valid=0, out_y=0, out_tag=0, in_ready=1, busy=0.
- WIDTH=32, STAGES=2, out_ready=1; issue tag=3 op=6 x1=0x00000001 -> two cycles later out_valid=1, out_tag=3, out_y=0xFFFFFFFF (and out_neg=1, out_zero=0 with LU_FLAGS_EN).
- Back-to-back issues of ops 0..7 with x1=0xF0F0F0F0, x2=0xFF00FF00 and tags 0..7 -> eight consecutive outputs in order:
  - 0xF000F000, 0x0FF00FF0, 0x0FFF0FFF, 0xFFF0FFF0, 0x0F0F0F0F, 0x000F000F, 0x0F0F0F10, 0xF00FF00F.
- Hold out_ready=0 while issuing continuously -> exactly STAGES ops accepted, then in_ready=0 and out_* stable; raise out_ready -> all ops drain in order, none lost or repeated.
- Pipeline full, assert flush for 1 cycle with a simultaneous in_valid -> next cycle busy=0, out_valid=0; the flush-cycle op never appears.
- Assert rst with 2 ops in flight and out_ready=0 -> next cycle all outputs at reset values; a subsequent op completes normally with latency STAGES.
